// File: rtl/exe_mem_pc_path.sv
// PC slice for the ID and EXE stages plus the EXE/MEM pipeline register.
// ID and EXE pass the PC through unchanged; EXE/MEM captures it for the MEM stage.
module exe_mem_pc_path #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] id_pc_in,
  output logic [WIDTH-1:0] id_pc_out,
  input  logic [WIDTH-1:0] exe_pc_in,
  output logic [WIDTH-1:0] exe_pc_out,
  input  logic             exe_mem_freeze,
  input  logic             exe_mem_flush,
  output logic [WIDTH-1:0] mem_pc_out
);

  logic [WIDTH-1:0] mem_pc_q;

  assign id_pc_out  = id_pc_in;
  assign exe_pc_out = exe_pc_in;

  // Flush inserts a zero bubble and takes priority over freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_pc_q <= '0;
    end else if (exe_mem_flush) begin
      mem_pc_q <= '0;
    end else if (!exe_mem_freeze) begin
      mem_pc_q <= exe_pc_out;
    end
  end

  assign mem_pc_out = mem_pc_q;

endmodule

// File: tb/tb_exe_mem_pc_path.sv
// Directed and randomized checks of the PC pass-through paths and the EXE/MEM register.
module tb_exe_mem_pc_path;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] id_pc_in;
  logic [W-1:0] id_pc_out;
  logic [W-1:0] exe_pc_in;
  logic [W-1:0] exe_pc_out;
  logic         exe_mem_freeze;
  logic         exe_mem_flush;
  logic [W-1:0] mem_pc_out;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem;

  exe_mem_pc_path #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_pc_in       (id_pc_in),
    .id_pc_out      (id_pc_out),
    .exe_pc_in      (exe_pc_in),
    .exe_pc_out     (exe_pc_out),
    .exe_mem_freeze (exe_mem_freeze),
    .exe_mem_flush  (exe_mem_flush),
    .mem_pc_out     (mem_pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural view of one rising edge: what the MEM stage should see next.
  function automatic logic [W-1:0] edge_result(input logic [W-1:0] held, input logic r,
                                               input logic fl, input logic fr,
                                               input logic [W-1:0] pc);
    if (!r)  return '0;
    if (fl)  return '0;
    if (fr)  return held;
    return pc;
  endfunction

  initial begin
    int pcs[4];
    pcs = '{4, 8, 12, 16};
    rst            = 1'b0;
    id_pc_in       = 32'h0000_0010;
    exe_pc_in      = 32'h0000_0040;
    exe_mem_freeze = 1'b0;
    exe_mem_flush  = 1'b0;
    #1;
    check("reset_initial", mem_pc_out, '0);

    // Held in reset for five edges
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_mem", mem_pc_out, '0);
      check("reset_id_pass", id_pc_out, 32'h0000_0010);
      check("reset_exe_pass", exe_pc_out, 32'h0000_0040);
    end

    // Streaming: each value appears one edge after it is applied
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exe_pc_in = W'(pcs[i]);
      exp_q.push_back(W'(pcs[i]));
      #1;
      check("stream_exe_pass", exe_pc_out, W'(pcs[i]));
      tick();
      check("stream_mem", mem_pc_out, exp_q.pop_front());
    end

    // Freeze holds 8 across three edges
    exe_pc_in = 32'd8;
    tick();
    check("freeze_setup", mem_pc_out, 32'd8);
    exe_pc_in = 32'd12;
    exe_mem_freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_hold", mem_pc_out, 32'd8);
    end
    exe_mem_freeze = 1'b0;
    tick();
    check("freeze_release", mem_pc_out, 32'd12);

    // Flush beats freeze
    exe_pc_in = 32'h0000_0100;
    tick();
    check("flush_setup", mem_pc_out, 32'h0000_0100);
    exe_mem_flush = 1'b1;
    exe_mem_freeze = 1'b1;
    tick();
    check("flush_priority", mem_pc_out, '0);
    exe_mem_flush = 1'b0;
    exe_mem_freeze = 1'b0;
    exe_pc_in = 32'h0000_0104;
    tick();
    check("flush_resume", mem_pc_out, 32'h0000_0104);

    // Asynchronous reset between edges
    exe_pc_in = 32'hFFFF_FFFC;
    tick();
    check("async_setup", mem_pc_out, 32'hFFFF_FFFC);
    #1;
    rst = 1'b0;
    #1;
    check("async_clear", mem_pc_out, '0);
    exe_pc_in = 32'h0000_0200;
    #1;
    rst = 1'b1;
    tick();
    check("async_first_load", mem_pc_out, 32'h0000_0200);

    // Edge while reset is low keeps the register at zero
    rst = 1'b0;
    exe_pc_in = 32'h0000_0300;
    tick();
    check("reset_over_edge", mem_pc_out, '0);
    rst = 1'b1;

    // Width boundary
    exe_pc_in = 32'hFFFF_FFFF;
    id_pc_in  = 32'hFFFF_FFFF;
    tick();
    check("width_ones", mem_pc_out, 32'hFFFF_FFFF);
    check("width_id_pass", id_pc_out, 32'hFFFF_FFFF);
    exe_pc_in = 32'h0000_0000;
    tick();
    check("width_zero", mem_pc_out, 32'h0000_0000);

    // Randomized traffic against the edge model
    model_mem = mem_pc_out;
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] nxt;
      rst            = ($urandom_range(0, 15) != 0);
      exe_mem_flush  = ($urandom_range(0, 7) == 0);
      exe_mem_freeze = ($urandom_range(0, 3) == 0);
      exe_pc_in      = W'($urandom);
      id_pc_in       = W'($urandom);
      if (!rst) model_mem = '0;
      #1;
      check("rand_id_pass", id_pc_out, id_pc_in);
      check("rand_exe_pass", exe_pc_out, exe_pc_in);
      check("rand_pre_edge", mem_pc_out, model_mem);
      nxt = edge_result(model_mem, rst, exe_mem_flush, exe_mem_freeze, exe_pc_in);
      exp_q.push_back(nxt);
      tick();
      model_mem = exp_q.pop_front();
      check("rand_mem", mem_pc_out, model_mem);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
